// File: rtl/design_31_lane_addsub.sv
// design_31_lane_addsub
//   LANES independent W-bit add/subtract lanes with optional unsigned
//   saturation, behind a STAGES-deep valid/ready pipeline.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start / start_ready input beat handshake (op, sat, a, b sampled on accept)
//   op                  0 = add, 1 = subtract (a - b)
//   sat                 0 = wrap, 1 = unsigned saturate
//   a, b                packed operands, lane i at [i*W +: W]
//   y, carry            packed results, per-lane carry/borrow (unsaturated)
//   valid / ready       output handshake
//   done_cnt            wrapping count of output transfers

// One arithmetic lane: purely combinational.
module design_31_lane_addsub_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_op,
    input  logic         i_sat,
    output logic [W-1:0] o_y,
    output logic         o_carry
);
    logic [W:0] w_r;

    always_comb begin
        // W+1 bit result: bit W is the add carry, or the borrow (a < b) on sub.
        w_r     = i_op ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
        o_carry = w_r[W];
        if (i_sat && w_r[W])
            o_y = i_op ? '0 : '1;
        else
            o_y = w_r[W-1:0];
    end
endmodule

module design_31_lane_addsub #(
    parameter int W      = 8,
    parameter int LANES  = 2,
    parameter int STAGES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               start_ready,
    input  logic               op,
    input  logic               sat,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic [LANES*W-1:0] y,
    output logic [LANES-1:0]   carry,
    output logic               valid,
    input  logic               ready,
    output logic [15:0]        done_cnt
);
    logic [LANES*W-1:0]                w_y;
    logic [LANES-1:0]                  w_c;
    logic                              w_stall;
    logic                              w_accept;
    logic [STAGES-1:0]                 r_vld;
    logic [STAGES-1:0][LANES*W-1:0]    r_y;
    logic [STAGES-1:0][LANES-1:0]      r_c;
    logic [15:0]                       r_done;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            design_31_lane_addsub_lane #(.W(W)) u_lane (
                .i_a     (a[gi*W +: W]),
                .i_b     (b[gi*W +: W]),
                .i_op    (op),
                .i_sat   (sat),
                .o_y     (w_y[gi*W +: W]),
                .o_carry (w_c[gi])
            );
        end
    endgenerate

    assign valid       = r_vld[STAGES-1];
    assign y           = r_y[STAGES-1];
    assign carry       = r_c[STAGES-1];
    assign done_cnt    = r_done;
    assign w_stall     = valid & ~ready;
    assign start_ready = rst_n & ~w_stall;
    assign w_accept    = start & start_ready;

    // The whole pipeline moves together or holds together; bubbles travel
    // like beats. Data registers only load when a real beat arrives, so the
    // output keeps its last result while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_y   <= '0;
            r_c   <= '0;
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_y[0] <= w_y;
                r_c[0] <= w_c;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_y[s] <= r_y[s-1];
                    r_c[s] <= r_c[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_done <= '0;
        else if (valid && ready)
            r_done <= r_done + 16'd1;
    end
endmodule

// File: tb/tb_design_31_lane_addsub.sv
module tb_design_31_lane_addsub;
    localparam int W = 8, LANES = 2, ST = 3, LW = W * LANES;

    typedef struct {
        logic [LW-1:0]    a, b;
        logic             op, sat;
        logic [LW-1:0]    y;
        logic [LANES-1:0] c;
    } vec_t;
    typedef struct {
        logic [LW-1:0]    y;
        logic [LANES-1:0] c;
    } res_t;

    logic clk = 0, rst_n = 0, start = 0, op = 0, sat = 0, ready = 1;
    logic start1 = 0, ready1 = 1;
    logic [LW-1:0] a = '0, b = '0;
    logic start_ready, valid, start_ready1, valid1;
    logic [LW-1:0] y, y1;
    logic [LANES-1:0] carry, carry1;
    logic [15:0] done_cnt, done_cnt1;

    design_31_lane_addsub #(.W(W), .LANES(LANES), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .op(op), .sat(sat), .a(a), .b(b), .y(y), .carry(carry),
        .valid(valid), .ready(ready), .done_cnt(done_cnt));

    design_31_lane_addsub #(.W(W), .LANES(LANES), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .start_ready(start_ready1),
        .op(op), .sat(sat), .a(a), .b(b), .y(y1), .carry(carry1),
        .valid(valid1), .ready(ready1), .done_cnt(done_cnt1));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on each lane.
    function automatic void model(input logic [LW-1:0] ma, input logic [LW-1:0] mb,
                                  input logic mop, input logic msat,
                                  output logic [LW-1:0] my, output logic [LANES-1:0] mc);
        int m, ai, bi, r, wr;
        bit cy;
        m = 1 << W;
        for (int i = 0; i < LANES; i++) begin
            ai = int'(ma[i*W +: W]);
            bi = int'(mb[i*W +: W]);
            if (!mop) begin r = ai + bi; cy = (r >= m); end
            else      begin r = ai - bi; cy = (ai < bi); end
            wr = ((r % m) + m) % m;
            if (msat && cy) wr = mop ? 0 : m - 1;
            my[i*W +: W] = W'(wr);
            mc[i] = cy;
        end
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    res_t q[$];
    res_t e;
    logic [15:0] m_cnt = 0;
    logic prev_stall = 0, p_v = 0;
    logic [LW-1:0] p_y = '0;
    logic [LANES-1:0] p_c = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_valid", valid, 0);
            check("rst_y", y, 0);
            check("rst_carry", carry, 0);
            check("rst_done", done_cnt, 0);
            check("rst_sready", start_ready, 0);
        end else begin
            check("start_ready", start_ready, !(valid && !ready));
            check("done_cnt", done_cnt, m_cnt);
            if (prev_stall) begin
                check("stall_valid", valid, p_v);
                check("stall_y", y, p_y);
                check("stall_carry", carry, p_c);
            end
            if (valid) begin
                check("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    check("sb_y", y, q[0].y);
                    check("sb_carry", carry, q[0].c);
                    if (ready) begin
                        void'(q.pop_front());
                        m_cnt++;
                    end
                end
            end
            if (start && start_ready) begin
                model(a, b, op, sat, e.y, e.c);
                q.push_back(e);
            end
            prev_stall = valid && !ready;
            p_v = valid; p_y = y; p_c = carry;
        end
    end

    // Reset discards everything in flight.
    initial forever begin
        @(negedge rst_n);
        q.delete();
        m_cnt = 0;
        prev_stall = 0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [LW-1:0] sa, input logic [LW-1:0] sb,
                             input logic sop, input logic ssat);
        logic ok;
        ok = 0;
        a = sa; b = sb; op = sop; sat = ssat; start = 1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = start_ready;
            @(posedge clk);
            #1;
        end
        start = 0;
        check("send_accept", ok, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        check(name, q.size(), 0);
    endtask

    vec_t tbl[7];
    logic got;
    int lat;
    logic [LW-1:0] sy, fa, fb, fy;
    logic [LANES-1:0] sc, fc;
    logic fop, fsat, drv_done;

    initial begin
        tbl[0] = '{16'h03F0, 16'h0420, 1'b0, 1'b0, 16'h0710, 2'b01};
        tbl[1] = '{16'h01F0, 16'h0120, 1'b0, 1'b1, 16'h02FF, 2'b01};
        tbl[2] = '{16'h0905, 16'h0509, 1'b1, 1'b1, 16'h0400, 2'b01};
        tbl[3] = '{16'h0905, 16'h0509, 1'b1, 1'b0, 16'h04FC, 2'b01};
        tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 2'b01};
        tbl[5] = '{16'h0080, 16'hFF80, 1'b1, 1'b0, 16'h0100, 2'b10};
        tbl[6] = '{16'h807F, 16'h8080, 1'b0, 1'b1, 16'hFFFF, 2'b10};

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("reset_valid", valid, 0);
            check("reset_sready", start_ready, 0);
            check("reset_done", done_cnt, 0);
        end
        @(posedge clk);
        #1 rst_n = 1;

        // Directed vectors, one at a time, checking latency and result.
        for (int i = 0; i < 7; i++) begin
            a = tbl[i].a; b = tbl[i].b; op = tbl[i].op; sat = tbl[i].sat; start = 1;
            @(posedge clk);
            #1 start = 0;
            got = 0; lat = 0;
            while (!got && lat < 20) begin
                @(negedge clk);
                lat++;
                got = valid;
            end
            check("vec_seen", got, 1);
            check("vec_latency", lat, ST);
            check("vec_y", y, tbl[i].y);
            check("vec_carry", carry, tbl[i].c);
            @(posedge clk);
            #1;
            if (i == 0) check("vec_done_first", done_cnt, 1);
        end
        check("vec_done_all", done_cnt, 7);

        // Backpressure: five beats, four stalled cycles once valid rises.
        do_reset();
        ready = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_beat(LW'($urandom), LW'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                got = 0;
                for (int t = 0; t < 30 && !got; t++) begin
                    @(negedge clk);
                    got = valid;
                end
                check("bp_valid_rise", got, 1);
                sy = y; sc = carry;
                check("bp_sready0", start_ready, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("bp_sready0", start_ready, 0);
                    check("bp_valid_hold", valid, 1);
                    check("bp_y_hold", y, sy);
                    check("bp_c_hold", carry, sc);
                end
                @(posedge clk);
                #1 ready = 1;
            end
        join
        drain("bp_drained");
        check("bp_done_cnt", done_cnt, 5);

        // Random beats against random backpressure.
        drv_done = 0;
        fork
            begin
                repeat (60) begin
                    send_beat(LW'($urandom), LW'($urandom), 1'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 ready = ($urandom_range(0, 3) != 0);
                end
                ready = 1;
            end
        join
        drain("rnd_drained");

        // Throughput: ten beats back-to-back on both depths.
        fa = LW'($urandom); fb = LW'($urandom); fop = 1'($urandom); fsat = 1'($urandom);
        model(fa, fb, fop, fsat, fy, fc);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (i == 0) begin a = fa; b = fb; op = fop; sat = fsat; end
                    else begin a = LW'($urandom); b = LW'($urandom); op = 1'($urandom); sat = 1'($urandom); end
                    start = 1; start1 = 1;
                    @(posedge clk);
                    #1;
                end
                start = 0; start1 = 0;
            end
            begin
                @(posedge clk);
                for (int j = 1; j <= ST + 11; j++) begin
                    @(negedge clk);
                    check("tp_valid", valid, (j >= ST && j <= ST + 9));
                    check("tp_valid_s1", valid1, (j >= 1 && j <= 10));
                    if (j == 1) begin
                        check("tp_s1_y", y1, fy);
                        check("tp_s1_carry", carry1, fc);
                    end
                end
            end
        join
        drain("tp_drained");

        // Reset pulse with two beats in flight.
        send_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_beat(16'h3333, 16'h4444, 1'b0, 1'b0);
        @(posedge clk);
        #2 check("mf_valid_pre", valid, 1);
        rst_n = 0;
        #1;
        check("mf_valid_async", valid, 0);
        check("mf_y_async", y, 0);
        check("mf_carry_async", carry, 0);
        check("mf_sready_async", start_ready, 0);
        check("mf_done_async", done_cnt, 0);
        #1 rst_n = 1;
        repeat (6) begin
            @(negedge clk);
            check("mf_no_stale", valid, 0);
        end
        @(posedge clk);
        #1;
        send_beat(tbl[0].a, tbl[0].b, tbl[0].op, tbl[0].sat);
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = valid;
        end
        check("mf_new_seen", got, 1);
        check("mf_new_y", y, tbl[0].y);
        check("mf_new_carry", carry, tbl[0].c);
        @(posedge clk);
        #1 check("mf_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
